// File: rtl/alu_digit_serial.sv
// Digit-serial binary/BCD add/subtract unit: one 4-bit digit per clock, LSD first.
// Result and N/Z/C/V are registered on entry to DONE and held until the next completion.
//
// state  | meaning
// IDLE   | waiting for START
// RUN    | processing digit idx, carry held in carry_q
// DONE   | one-cycle completion pulse; START here begins the next operation
module alu_digit_serial #(
  parameter int DIGITS = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [4*DIGITS-1:0]   INA,
  input  logic [4*DIGITS-1:0]   INB,
  input  logic                  SBC,
  input  logic                  CIN,
  input  logic                  BCD,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [4*DIGITS-1:0]   OUT,
  output logic                  N,
  output logic                  Z,
  output logic                  C,
  output logic                  V
);

  localparam int WIDTH = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  b_eff;
  logic [WIDTH-1:0]  shadow_q;
  logic [WIDTH-1:0]  shadow_nxt;
  logic              sbc_q;
  logic              bcd_q;
  logic              carry_q;
  logic [IDX_W-1:0]  idx_q;
  logic [3:0]        dig_a;
  logic [3:0]        dig_b;
  logic [3:0]        dig;
  logic [4:0]        sum;
  logic              co;

  assign b_eff = sbc_q ? ~b_q : b_q;

  always_comb begin
    dig_a = a_q[4*int'(idx_q) +: 4];
    dig_b = b_eff[4*int'(idx_q) +: 4];
    sum   = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0000, carry_q};
    dig   = sum[3:0];
    co    = sum[4];
    if (bcd_q) begin
      if (!sbc_q) begin
        co = (sum > 5'd9);
        if (sum > 5'd9) dig = sum[3:0] + 4'd6;
      end else begin
        // decimal subtract: no carry out of the nibble means a borrow, correct by +10
        co = sum[4];
        if (!sum[4]) dig = sum[3:0] + 4'd10;
      end
    end
    shadow_nxt = shadow_q;
    shadow_nxt[4*int'(idx_q) +: 4] = dig;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      shadow_q <= '0;
      sbc_q    <= 1'b0;
      bcd_q    <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      OUT      <= '0;
      N        <= 1'b0;
      Z        <= 1'b0;
      C        <= 1'b0;
      V        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            a_q     <= INA;
            b_q     <= INB;
            sbc_q   <= SBC;
            bcd_q   <= BCD;
            carry_q <= CIN;
            idx_q   <= '0;
            BUSY    <= 1'b1;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          shadow_q <= shadow_nxt;
          carry_q  <= co;
          if (idx_q == LAST) begin
            OUT   <= shadow_nxt;
            N     <= shadow_nxt[WIDTH-1];
            Z     <= (shadow_nxt == '0);
            C     <= co;
            V     <= (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (shadow_nxt[WIDTH-1] != a_q[WIDTH-1]);
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        S_DONE: begin
          DONE <= 1'b0;
          if (START) begin
            a_q     <= INA;
            b_q     <= INB;
            sbc_q   <= SBC;
            bcd_q   <= BCD;
            carry_q <= CIN;
            idx_q   <= '0;
            BUSY    <= 1'b1;
            state   <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_digit_serial.sv
// Scoreboard bench for alu_digit_serial (DIGITS=4): driver pushes expected results,
// a negedge monitor pops them on DONE and checks value, flags, latency and hold behaviour.
module tb_alu_digit_serial;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, sbc, cin, bcd;
  logic [15:0] ina, inb;
  logic        busy, done;
  logic [15:0] out_w;
  logic        n_f, z_f, c_f, v_f;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] out;
    logic        n, z, c, v;
    time         t;
    bit          b2b;
    string       name;
  } exp_t;

  exp_t        q[$];
  logic [19:0] hold = '0;
  time         last_done = 0;

  alu_digit_serial #(.DIGITS(D)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .INA(ina), .INB(inb),
    .SBC(sbc), .CIN(cin), .BCD(bcd), .BUSY(busy), .DONE(done),
    .OUT(out_w), .N(n_f), .Z(z_f), .C(c_f), .V(v_f)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] o, input logic n, z, c, v);
    exp_t e;
    e.out = o; e.n = n; e.z = z; e.c = c; e.v = v;
    e.t = 0; e.b2b = 0; e.name = "";
    return e;
  endfunction

  function automatic int bcd2int(input logic [15:0] x);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(x[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int val);
    logic [15:0] r;
    int w = val;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(w % 10);
      w = w / 10;
    end
    return r;
  endfunction

  // Reference: whole-number arithmetic (integer sums for binary, decimal values for BCD)
  function automatic exp_t model(input logic [15:0] a, b, input logic s, ci, dm);
    logic [15:0] bb, o;
    logic [16:0] s17;
    logic        c, v;
    int          sr, r;
    bb = s ? ~b : b;
    if (!dm) begin
      s17 = {1'b0, a} + {1'b0, bb} + {16'h0, ci};
      o   = s17[15:0];
      c   = s17[16];
      sr  = int'($signed(a)) + int'($signed(bb)) + int'(ci);
      v   = (sr > 32767) || (sr < -32768);
    end else begin
      if (!s) begin
        r = bcd2int(a) + bcd2int(b) + int'(ci);
        c = (r >= 10000);
        r = r % 10000;
      end else begin
        r = bcd2int(a) - bcd2int(b) - (1 - int'(ci));
        c = (r >= 0);
        if (r < 0) r = r + 10000;
      end
      o = int2bcd(r);
      v = (a[15] == bb[15]) && (o[15] != a[15]);
    end
    return mk(o, o[15], (o == 16'h0), c, v);
  endfunction

  task automatic issue(input string name, input logic [15:0] a, b, input logic s, ci, dm,
                       input bit wait_done, input bit use_exp, input exp_t ex);
    exp_t e;
    int   n = 0;
    bit   ok = 0;
    while (!ok && n < 100) begin
      @(negedge clk);
      n++;
      ok = wait_done ? (done === 1'b1) : (busy === 1'b0);
    end
    if (!ok) chk({name, "_accept_timeout"}, 32'(n), 32'(0));
    ina = a; inb = b; sbc = s; cin = ci; bcd = dm; start = 1'b1;
    @(posedge clk);
    e = use_exp ? ex : model(a, b, s, ci, dm);
    e.t = $time; e.b2b = wait_done; e.name = name;
    q.push_back(e);
    #1 start = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'(0));
        end else begin
          e = q.pop_front();
          chk({e.name, "_out"}, 32'(out_w), 32'(e.out));
          chk({e.name, "_nzcv"}, {28'h0, n_f, z_f, c_f, v_f}, {28'h0, e.n, e.z, e.c, e.v});
          chk({e.name, "_latency"}, 32'($time - e.t), 32'(D * 10 + 5));
          if (e.b2b) chk({e.name, "_b2b_gap"}, 32'($time - last_done), 32'((D + 1) * 10));
          last_done = $time;
          hold = {e.out, e.n, e.z, e.c, e.v};
        end
      end else begin
        chk("hold", {12'h0, out_w, n_f, z_f, c_f, v_f}, {12'h0, hold});
      end
    end
  end

  initial begin
    exp_t nx;
    logic [15:0] ra, rb;
    logic rs, rc, rd;
    nx = mk(16'h0, 0, 0, 0, 0);
    rst_n = 1'b0; start = 0; ina = 0; inb = 0; sbc = 0; cin = 0; bcd = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy_done", {30'h0, busy, done}, 32'h0);
    chk("reset_out", 32'(out_w), 32'h0);
    chk("reset_nzcv", {28'h0, n_f, z_f, c_f, v_f}, 32'h0);
    rst_n = 1'b1;

    issue("bin_add", 16'h1234, 16'h0FFF, 0, 0, 0, 0, 1, mk(16'h2233, 0, 0, 0, 0));
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      chk("run_busy_done", {30'h0, busy, done}, 32'h2);
    end
    @(negedge clk);
    chk("done_busy", 32'(busy), 32'h0);

    issue("bcd_add", 16'h9999, 16'h0001, 0, 0, 1, 0, 1, mk(16'h0000, 0, 1, 1, 0));
    @(posedge clk); #1;
    start = 1'b1; ina = 16'h5555; inb = 16'h4444; sbc = 1; cin = 0; bcd = 0;
    @(posedge clk); #1 start = 1'b0;

    issue("bcd_sub1", 16'h1000, 16'h0001, 1, 1, 1, 0, 1, mk(16'h0999, 0, 0, 1, 0));
    issue("bcd_sub2", 16'h0000, 16'h0001, 1, 1, 1, 1, 1, mk(16'h9999, 1, 0, 0, 0));
    issue("bin_ovf_sub", 16'h8000, 16'h0001, 1, 1, 0, 0, 1, mk(16'h7FFF, 0, 0, 1, 1));
    issue("bin_ovf_add", 16'h7FFF, 16'h0001, 0, 0, 0, 1, 1, mk(16'h8000, 1, 0, 0, 1));
    issue("bcd_nondec", 16'h000A, 16'h0000, 0, 0, 1, 0, 1, mk(16'h0010, 0, 0, 0, 0));

    issue("pre_reset", 16'hABCD, 16'h1111, 0, 0, 0, 0, 0, nx);
    @(posedge clk); #2;
    rst_n = 1'b0;
    q.delete();
    hold = '0;
    #1;
    chk("midrun_reset_busy_done", {30'h0, busy, done}, 32'h0);
    chk("midrun_reset_out", 32'(out_w), 32'h0);
    chk("midrun_reset_nzcv", {28'h0, n_f, z_f, c_f, v_f}, 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    issue("post_reset", 16'h0042, 16'h0017, 0, 1, 0, 0, 0, nx);

    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (rd) begin
        ra = int2bcd(int'($urandom_range(0, 9999)));
        rb = int2bcd(int'($urandom_range(0, 9999)));
      end else begin
        ra = 16'($urandom);
        rb = 16'($urandom);
      end
      issue("rand", ra, rb, rs, rc, rd, ($urandom_range(0, 2) == 0), 0, nx);
    end

    begin
      int n = 0;
      while (q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (3) @(negedge clk);
    chk("drain", 32'(q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
